// File: rtl/vx_commit_pkg.sv
// Shared types for the commit->scheduler in-flight tracker.
package vx_commit_pkg;

  // Lane structs carry a fixed-width warp id so they stay independent of NUM_WARPS.
  localparam int unsigned WID_MAX = 8;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    DONE   = 2'd2,
    HALTED = 2'd3
  } warp_state_e;

  typedef struct packed {
    logic               valid;
    logic [WID_MAX-1:0] wid;
    logic               halt;
  } commit_lane_t;

endpackage

// File: rtl/vx_warp_pending_ctr.sv
// Per-warp in-flight counter with the halt-drain state machine.
//  state  | meaning
//  RUN    | dispatch allowed, waiting for a halt commit
//  DRAIN  | halt committed, waiting for in-flight count to reach zero
//  DONE   | drained, halt request offered to the scheduler
//  HALTED | scheduler accepted the halt, waiting for restart
module vx_warp_pending_ctr
  import vx_commit_pkg::*;
#(
  parameter int PENDING_WIDTH = 4,
  parameter int CNT_W         = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CNT_W-1:0]         inc_i,
  input  logic [CNT_W-1:0]         dec_i,
  input  logic                     halt_hit_i,
  input  logic                     grant_i,
  input  logic                     restart_i,
  output logic [PENDING_WIDTH-1:0] cnt_o,
  output warp_state_e              state_o,
  output logic                     underflow_o
);

  localparam int SW = PENDING_WIDTH + CNT_W;

  logic [PENDING_WIDTH-1:0] cnt_q, cnt_d;
  warp_state_e              state_q, state_d;
  logic [SW-1:0]            sum;

  always_comb begin
    sum         = SW'(cnt_q) + SW'(inc_i);
    cnt_d       = '0;
    underflow_o = 1'b0;
    if (SW'(dec_i) > sum) begin
      underflow_o = 1'b1;
    end else begin
      cnt_d = PENDING_WIDTH'(sum - SW'(dec_i));
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt_hit_i) state_d = DRAIN;
      DRAIN:   if (cnt_q == '0) state_d = DONE;
      DONE:    if (grant_i) state_d = HALTED;
      HALTED:  if (restart_i) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      state_q <= RUN;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign state_o = state_q;

endmodule

// File: rtl/vx_commit_sched_tracker.sv
// Tracks in-flight instructions per warp, gates dispatch on saturation and
// presents drained halts to the scheduler over a valid/ready channel.
module vx_commit_sched_tracker
  import vx_commit_pkg::*;
#(
  parameter int NUM_WARPS     = 4,
  parameter int ISSUE_WIDTH   = 1,
  parameter int PENDING_WIDTH = 4,
  localparam int NW_WIDTH     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [ISSUE_WIDTH-1:0]          dispatch_valid,
  input  logic [ISSUE_WIDTH*NW_WIDTH-1:0] dispatch_wid,
  output logic [ISSUE_WIDTH-1:0]          dispatch_ready,
  input  logic [ISSUE_WIDTH-1:0]          commit_valid,
  input  logic [ISSUE_WIDTH*NW_WIDTH-1:0] commit_wid,
  input  logic [ISSUE_WIDTH-1:0]          commit_halt,
  input  logic [NUM_WARPS-1:0]            warp_restart,
  output logic                            halt_req_valid,
  output logic [NW_WIDTH-1:0]             halt_req_wid,
  input  logic                            halt_req_ready,
  output logic [NUM_WARPS-1:0]            warp_pending,
  output logic [NUM_WARPS-1:0]            warp_halted,
  output logic                            err_underflow
);

  localparam int CNT_W = $clog2(ISSUE_WIDTH + 1);
  localparam int CMP_W = PENDING_WIDTH + CNT_W + 1;
  localparam logic [CMP_W-1:0] PEND_MAX = CMP_W'((1 << PENDING_WIDTH) - 1);

  commit_lane_t             cl [ISSUE_WIDTH];
  commit_lane_t             dl [ISSUE_WIDTH];
  logic [PENDING_WIDTH-1:0] cnt [NUM_WARPS];
  warp_state_e              state [NUM_WARPS];
  logic [CNT_W-1:0]         inc [NUM_WARPS];
  logic [CNT_W-1:0]         dec [NUM_WARPS];
  logic [NUM_WARPS-1:0]     halt_hit, grant, uf, done;
  logic [ISSUE_WIDTH-1:0]   ready_raw;
  logic [NW_WIDTH-1:0]      prio_wid, wid_q;
  logic                     hold_q, err_q;

  always_comb begin
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      cl[i].valid = commit_valid[i];
      cl[i].wid   = WID_MAX'(commit_wid[i*NW_WIDTH +: NW_WIDTH]);
      cl[i].halt  = commit_halt[i];
      dl[i].valid = dispatch_valid[i];
      dl[i].wid   = WID_MAX'(dispatch_wid[i*NW_WIDTH +: NW_WIDTH]);
      dl[i].halt  = 1'b0;
    end
  end

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      dec[w]      = '0;
      halt_hit[w] = 1'b0;
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
        if (cl[i].valid && cl[i].wid == WID_MAX'(w)) begin
          dec[w] = dec[w] + CNT_W'(1);
          if (cl[i].halt) halt_hit[w] = 1'b1;
        end
      end
    end
  end

  // Lanes are granted in index order; each accepted lane consumes one slot of headroom.
  always_comb begin
    ready_raw = '0;
    for (int w = 0; w < NUM_WARPS; w++) inc[w] = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (dl[i].wid == WID_MAX'(w)) begin
          if (state[w] == RUN &&
              (CMP_W'(cnt[w]) + CMP_W'(inc[w]) + CMP_W'(1)) <= PEND_MAX) begin
            ready_raw[i] = 1'b1;
          end
          if (dl[i].valid && ready_raw[i]) inc[w] = inc[w] + CNT_W'(1);
        end
      end
    end
  end

  assign dispatch_ready = reset_n ? ready_raw : '0;

  for (genvar g = 0; g < NUM_WARPS; g++) begin : g_warp
    vx_warp_pending_ctr #(
      .PENDING_WIDTH(PENDING_WIDTH),
      .CNT_W        (CNT_W)
    ) u_ctr (
      .clk        (clk),
      .rst_n      (reset_n),
      .inc_i      (inc[g]),
      .dec_i      (dec[g]),
      .halt_hit_i (halt_hit[g]),
      .grant_i    (grant[g]),
      .restart_i  (warp_restart[g]),
      .cnt_o      (cnt[g]),
      .state_o    (state[g]),
      .underflow_o(uf[g])
    );
    assign done[g]         = (state[g] == DONE);
    assign warp_pending[g] = |cnt[g];
    assign warp_halted[g]  = (state[g] == HALTED);
    assign grant[g]        = halt_req_valid & halt_req_ready & (halt_req_wid == NW_WIDTH'(g));
  end

  always_comb begin
    prio_wid = '0;
    for (int w = NUM_WARPS - 1; w >= 0; w--) begin
      if (done[w]) prio_wid = NW_WIDTH'(w);
    end
  end

  // A stalled request keeps its warp even if a lower-index warp drains meanwhile.
  assign halt_req_valid = |done;
  assign halt_req_wid   = hold_q ? wid_q : prio_wid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= 1'b0;
      wid_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      hold_q <= halt_req_valid & ~halt_req_ready;
      wid_q  <= halt_req_wid;
      err_q  <= err_q | (|uf);
    end
  end

  assign err_underflow = err_q;

endmodule

// File: tb/tb_vx_commit_sched_tracker.sv
// Bench for vx_commit_sched_tracker: vector table, directed corner sequences,
// and random traffic checked against an in-bench reference model.
module tb_vx_commit_sched_tracker;

  localparam int NWARP = 4;
  localparam int MAXC  = 15;
  localparam int ST_RUN = 0, ST_DRAIN = 1, ST_DONE = 2, ST_HALTED = 3;

  logic       clk, reset_n;
  logic [1:0] dispatch_valid, dispatch_ready, commit_valid, commit_halt;
  logic [3:0] dispatch_wid, commit_wid, warp_restart, warp_pending, warp_halted;
  logic       halt_req_valid, halt_req_ready, err_underflow;
  logic [1:0] halt_req_wid;

  int n_cmp = 0;
  int n_err = 0;

  int   m_cnt [NWARP];
  int   m_st  [NWARP];
  int   m_inc [NWARP];
  bit   m_err;
  int   m_held;
  logic [1:0] m_rdy;

  typedef struct {
    logic [1:0] dv;
    logic [3:0] dw;
    logic [1:0] cv;
    logic [3:0] cw;
    logic [1:0] exp_ready;
    logic [3:0] exp_pending;
  } vec_t;
  vec_t vecs [6];

  vx_commit_sched_tracker #(.NUM_WARPS(4), .ISSUE_WIDTH(2), .PENDING_WIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .dispatch_valid(dispatch_valid), .dispatch_wid(dispatch_wid), .dispatch_ready(dispatch_ready),
    .commit_valid(commit_valid), .commit_wid(commit_wid), .commit_halt(commit_halt),
    .warp_restart(warp_restart),
    .halt_req_valid(halt_req_valid), .halt_req_wid(halt_req_wid), .halt_req_ready(halt_req_ready),
    .warp_pending(warp_pending), .warp_halted(warp_halted), .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model_reset();
    for (int w = 0; w < NWARP; w++) begin
      m_cnt[w] = 0;
      m_st[w]  = ST_RUN;
    end
    m_err  = 1'b0;
    m_held = -1;
  endfunction

  // A lane may dispatch if its warp is running and still has room after the lanes before it.
  function automatic void model_ready();
    int w;
    m_rdy = 2'b00;
    for (int k = 0; k < NWARP; k++) m_inc[k] = 0;
    for (int i = 0; i < 2; i++) begin
      w = int'(dispatch_wid[i*2 +: 2]);
      if (m_st[w] == ST_RUN && m_cnt[w] + m_inc[w] + 1 <= MAXC) begin
        m_rdy[i] = 1'b1;
        if (dispatch_valid[i]) m_inc[w]++;
      end
    end
    if (!reset_n) m_rdy = 2'b00;
  endfunction

  function automatic bit model_valid();
    bit v = 1'b0;
    for (int w = 0; w < NWARP; w++) if (m_st[w] == ST_DONE) v = 1'b1;
    return v;
  endfunction

  function automatic int model_wid();
    if (m_held >= 0) return m_held;
    for (int w = 0; w < NWARP; w++) if (m_st[w] == ST_DONE) return w;
    return 0;
  endfunction

  function automatic void model_step();
    int  nst [NWARP];
    int  ncnt [NWARP];
    int  dec, wid, t;
    bit  hh, v, acc;
    model_ready();
    v   = model_valid();
    wid = model_wid();
    acc = v && halt_req_ready;
    for (int w = 0; w < NWARP; w++) begin
      dec = 0;
      hh  = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (commit_valid[i] && int'(commit_wid[i*2 +: 2]) == w) begin
          dec++;
          if (commit_halt[i]) hh = 1'b1;
        end
      end
      nst[w] = m_st[w];
      if (m_st[w] == ST_RUN && hh) nst[w] = ST_DRAIN;
      else if (m_st[w] == ST_DRAIN && m_cnt[w] == 0) nst[w] = ST_DONE;
      else if (m_st[w] == ST_DONE && acc && wid == w) nst[w] = ST_HALTED;
      else if (m_st[w] == ST_HALTED && warp_restart[w]) nst[w] = ST_RUN;
      t = m_cnt[w] + m_inc[w] - dec;
      if (t < 0) begin
        t = 0;
        m_err = 1'b1;
      end
      ncnt[w] = t;
    end
    for (int w = 0; w < NWARP; w++) begin
      m_st[w]  = nst[w];
      m_cnt[w] = ncnt[w];
    end
    m_held = (v && !halt_req_ready) ? wid : -1;
  endfunction

  task automatic check_outputs();
    logic [3:0] ep, eh;
    bit ev;
    model_ready();
    ep = 4'b0;
    eh = 4'b0;
    for (int w = 0; w < NWARP; w++) begin
      ep[w] = (m_cnt[w] != 0);
      eh[w] = (m_st[w] == ST_HALTED);
    end
    ev = model_valid();
    chk("dispatch_ready", 32'(dispatch_ready), 32'(m_rdy));
    chk("warp_pending", 32'(warp_pending), 32'(ep));
    chk("warp_halted", 32'(warp_halted), 32'(eh));
    chk("halt_req_valid", 32'(halt_req_valid), 32'(ev));
    if (ev) chk("halt_req_wid", 32'(halt_req_wid), 32'(model_wid()));
    chk("err_underflow", 32'(err_underflow), 32'(m_err));
  endtask

  // Inputs are driven just after a rising edge, checked at the falling edge, model advanced at the rising edge.
  task automatic drive(input logic [1:0] dv, input logic [3:0] dw, input logic [1:0] cv,
                       input logic [3:0] cw, input logic [1:0] ch, input logic [3:0] rs,
                       input logic hr);
    dispatch_valid = dv;
    dispatch_wid   = dw;
    commit_valid   = cv;
    commit_wid     = cw;
    commit_halt    = ch;
    warp_restart   = rs;
    halt_req_ready = hr;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    if (reset_n) model_step();
    else model_reset();
    #1;
  endtask

  task automatic idle(input logic hr);
    drive(2'b00, 4'h0, 2'b00, 4'h0, 2'b00, 4'h0, hr);
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_ready"}, 32'(dispatch_ready), 32'd0);
    chk({nm, "_pending"}, 32'(warp_pending), 32'd0);
    chk({nm, "_halted"}, 32'(warp_halted), 32'd0);
    chk({nm, "_valid"}, 32'(halt_req_valid), 32'd0);
    chk({nm, "_wid"}, 32'(halt_req_wid), 32'd0);
    chk({nm, "_err"}, 32'(err_underflow), 32'd0);
  endtask

  task automatic random_phase(input int cycles);
    logic [1:0] cv, ch;
    logic [3:0] cw;
    int avail [NWARP];
    int w;
    for (int n = 0; n < cycles; n++) begin
      for (int k = 0; k < NWARP; k++) avail[k] = m_cnt[k];
      cv = 2'b00;
      ch = 2'b00;
      cw = 4'h0;
      for (int i = 0; i < 2; i++) begin
        w = int'($urandom_range(0, 3));
        cw[i*2 +: 2] = 2'(w);
        if ($urandom_range(0, 1) == 1 && avail[w] > 0) begin
          cv[i] = 1'b1;
          avail[w]--;
        end else if ($urandom_range(0, 299) == 0) begin
          cv[i] = 1'b1;
        end
        ch[i] = cv[i] && ($urandom_range(0, 15) == 0);
      end
      drive(2'($urandom_range(0, 3)), 4'($urandom), cv, cw, ch,
            4'($urandom & $urandom), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    vecs[0] = '{2'b11, 4'b0101, 2'b00, 4'b0000, 2'b11, 4'b0000};
    vecs[1] = '{2'b01, 4'b0010, 2'b01, 4'b0001, 2'b11, 4'b0010};
    vecs[2] = '{2'b00, 4'b0000, 2'b11, 4'b1001, 2'b11, 4'b0110};
    vecs[3] = '{2'b10, 4'b1100, 2'b00, 4'b0000, 2'b11, 4'b0000};
    vecs[4] = '{2'b00, 4'b0000, 2'b10, 4'b1100, 2'b11, 4'b1000};
    vecs[5] = '{2'b00, 4'b0000, 2'b00, 4'b0000, 2'b11, 4'b0000};

    model_reset();
    reset_n = 1'b0;
    dispatch_valid = '0; dispatch_wid = '0; commit_valid = '0; commit_wid = '0;
    commit_halt = '0; warp_restart = '0; halt_req_ready = 1'b0;

    // reset held with random inputs
    for (int n = 0; n < 5; n++) begin
      drive(2'($urandom), 4'($urandom), 2'($urandom), 4'($urandom), 2'($urandom),
            4'($urandom), 1'($urandom));
      check_all_zero("reset");
    end
    reset_n = 1'b1;
    idle(1'b0);
    chk("post_reset_ready", 32'(dispatch_ready), 32'h3);
    chk("post_reset_pending", 32'(warp_pending), 32'h0);

    // vector table
    for (int v = 0; v < 6; v++) begin
      dispatch_valid = vecs[v].dv; dispatch_wid = vecs[v].dw;
      commit_valid = vecs[v].cv; commit_wid = vecs[v].cw;
      commit_halt = 2'b00; warp_restart = 4'h0; halt_req_ready = 1'b0;
      #1;
      chk("vec_ready", 32'(dispatch_ready), 32'(vecs[v].exp_ready));
      chk("vec_pending", 32'(warp_pending), 32'(vecs[v].exp_pending));
      drive(vecs[v].dv, vecs[v].dw, vecs[v].cv, vecs[v].cw, 2'b00, 4'h0, 1'b0);
    end

    // saturation of warp 2 on lane 0
    for (int n = 0; n < 15; n++) drive(2'b01, 4'b0010, 2'b00, 4'h0, 2'b00, 4'h0, 1'b0);
    chk("sat_ready_low", 32'(dispatch_ready), 32'h2);
    drive(2'b01, 4'b0010, 2'b01, 4'b0010, 2'b00, 4'h0, 1'b0);
    chk("sat_ready_after_commit", 32'(dispatch_ready), 32'h3);
    drive(2'b01, 4'b0010, 2'b00, 4'h0, 2'b00, 4'h0, 1'b0);
    chk("sat_ready_refilled", 32'(dispatch_ready), 32'h2);
    for (int n = 0; n < 7; n++) drive(2'b00, 4'h0, 2'b11, 4'b1010, 2'b00, 4'h0, 1'b0);
    drive(2'b00, 4'h0, 2'b01, 4'b0010, 2'b00, 4'h0, 1'b0);
    chk("sat_drained", 32'(warp_pending), 32'h0);

    // two lanes to warp 1 at count 14: only lane 0 fits
    for (int n = 0; n < 7; n++) drive(2'b11, 4'b0101, 2'b00, 4'h0, 2'b00, 4'h0, 1'b0);
    dispatch_valid = 2'b11; dispatch_wid = 4'b0101; commit_valid = 2'b00;
    #1;
    chk("lane_prefix_ready", 32'(dispatch_ready), 32'h1);
    drive(2'b11, 4'b0101, 2'b00, 4'h0, 2'b00, 4'h0, 1'b0);
    chk("lane_prefix_full", 32'(dispatch_ready), 32'h0);
    for (int n = 0; n < 7; n++) drive(2'b00, 4'h0, 2'b11, 4'b0101, 2'b00, 4'h0, 1'b0);
    drive(2'b00, 4'h0, 2'b01, 4'b0001, 2'b00, 4'h0, 1'b0);
    chk("lane_prefix_drained", 32'(warp_pending), 32'h0);

    // halt drain on warp 0 with a stalled request
    drive(2'b11, 4'b0000, 2'b00, 4'h0, 2'b00, 4'h0, 1'b0);
    drive(2'b01, 4'b0000, 2'b00, 4'h0, 2'b00, 4'h0, 1'b0);
    drive(2'b00, 4'h0, 2'b01, 4'b0000, 2'b01, 4'h0, 1'b0);
    chk("drain_ready_low", 32'(dispatch_ready), 32'h0);
    chk("drain_no_req", 32'(halt_req_valid), 32'h0);
    drive(2'b00, 4'h0, 2'b11, 4'b0000, 2'b00, 4'h0, 1'b0);
    chk("drain_no_req_yet", 32'(halt_req_valid), 32'h0);
    idle(1'b0);
    chk("drain_req_valid", 32'(halt_req_valid), 32'h1);
    chk("drain_req_wid", 32'(halt_req_wid), 32'h0);
    idle(1'b0);
    idle(1'b0);
    chk("drain_req_held", 32'(halt_req_valid), 32'h1);
    idle(1'b1);
    chk("drain_halted", 32'(warp_halted), 32'h1);
    chk("drain_req_cleared", 32'(halt_req_valid), 32'h0);
    drive(2'b00, 4'h0, 2'b00, 4'h0, 2'b00, 4'b0001, 1'b0);
    chk("drain_restarted", 32'(warp_halted), 32'h0);
    chk("drain_ready_back", 32'(dispatch_ready), 32'h3);

    // warps 1 and 3 drain together: lower index served first
    drive(2'b11, 4'b1101, 2'b00, 4'h0, 2'b00, 4'h0, 1'b0);
    drive(2'b00, 4'h0, 2'b11, 4'b1101, 2'b11, 4'h0, 1'b0);
    idle(1'b0);
    chk("prio_first", 32'(halt_req_wid), 32'h1);
    idle(1'b1);
    chk("prio_second_valid", 32'(halt_req_valid), 32'h1);
    chk("prio_second", 32'(halt_req_wid), 32'h3);
    idle(1'b1);
    chk("prio_halted", 32'(warp_halted), 32'hA);
    drive(2'b00, 4'h0, 2'b00, 4'h0, 2'b00, 4'b1010, 1'b0);
    chk("prio_restarted", 32'(warp_halted), 32'h0);

    // underflow is sticky; async reset mid-drain clears everything
    drive(2'b00, 4'h0, 2'b01, 4'b0010, 2'b00, 4'h0, 1'b0);
    chk("uf_set", 32'(err_underflow), 32'h1);
    chk("uf_cnt_zero", 32'(warp_pending), 32'h0);
    idle(1'b0);
    idle(1'b0);
    chk("uf_sticky", 32'(err_underflow), 32'h1);
    drive(2'b11, 4'b0000, 2'b00, 4'h0, 2'b00, 4'h0, 1'b0);
    drive(2'b00, 4'h0, 2'b01, 4'b0000, 2'b01, 4'h0, 1'b0);
    drive(2'b00, 4'h0, 2'b01, 4'b0000, 2'b00, 4'h0, 1'b0);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    drive(2'($urandom), 4'($urandom), 2'($urandom), 4'($urandom), 2'($urandom), 4'h0, 1'b1);
    reset_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      idle(1'b1);
      chk("midreset_no_req", 32'(halt_req_valid), 32'h0);
    end

    // random traffic against the model
    random_phase(1500);
    reset_n = 1'b0;
    model_reset();
    idle(1'b0);
    idle(1'b0);
    reset_n = 1'b1;
    random_phase(1500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
